// File: rtl/baud_rate_generator_pkg.sv
//------------------------------------------------------------------------------
// Module  : baud_rate_generator_pkg
// Brief   : Shared UART constants and the rounded baud divisor function.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package baud_rate_generator_pkg;

  localparam longint DEFAULT_CLOCK_FREQ = 100_000_000;
  localparam longint DEFAULT_BAUD_RATE  = 9600;
  localparam longint DEFAULT_OVERSAMPLE = 16;

  // Rounded-to-nearest divisor; a zero rate yields 0 so the caller's checks fire
  function automatic longint baud_divisor(input longint clk, input longint baud,
                                          input longint os);
    longint rate;
    rate = baud * os;
    if (rate <= 0)
      return 64'sd0;
    return (clk + rate / 2) / rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_rate_generator_if.sv
//------------------------------------------------------------------------------
// Module  : baud_rate_generator_if
// Brief   : Carries the oversampling tick from the generator to UART consumers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface baud_rate_generator_if;
  logic tck;

  modport master (output tck);
  modport slave  (input  tck);
endinterface

`default_nettype wire

// File: rtl/baud_rate_generator.sv
//------------------------------------------------------------------------------
// Module  : baud_rate_generator
// Brief   : Free-running divider emitting a one-cycle tick every DIVISOR clocks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module baud_rate_generator
  import baud_rate_generator_pkg::*;
#(
  parameter longint CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter longint BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter longint OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  wire logic i_clk,
  input  wire logic i_reset,
  output logic      o_brg_tck
);

  localparam longint RATE      = BAUD_RATE * OVERSAMPLE;
  localparam longint DIVISOR_L = baud_divisor(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int     DIVISOR   = int'(DIVISOR_L);
  localparam int     CNT_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam longint PRODUCT   = DIVISOR_L * RATE;
  localparam longint ABS_ERR   = (PRODUCT > CLOCK_FREQ) ? (PRODUCT - CLOCK_FREQ)
                                                        : (CLOCK_FREQ - PRODUCT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  // Bad parameterisations stop elaboration rather than yield a wrong line rate
  if (CLOCK_FREQ <= 0 || BAUD_RATE <= 0 || OVERSAMPLE <= 0) begin : g_chk_positive
    $fatal(1, "baud_rate_generator: CLOCK_FREQ, BAUD_RATE and OVERSAMPLE must be > 0");
  end

  if (DIVISOR_L < 2) begin : g_chk_divisor
    $fatal(1, "baud_rate_generator: DIVISOR must be >= 2");
  end

  if (ABS_ERR * 50 > CLOCK_FREQ) begin : g_chk_error
    $fatal(1, "baud_rate_generator: tick frequency error exceeds 2 percent");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_tck;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_tck <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_tck <= 1'b0;
    end
  end

  assign o_brg_tck = r_tck;

endmodule

`default_nettype wire

// File: tb/tb_baud_rate_generator.sv
//------------------------------------------------------------------------------
// Module  : tb_baud_rate_generator
// Brief   : Directed bench for three divisor configurations (651, 10, 27).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_baud_rate_generator;
  import baud_rate_generator_pkg::*;

  logic clk;
  logic r_rst0, r_rst1, r_rst2;
  int   checks;
  int   errors;
  int   hits[$];

  baud_rate_generator_if u_if0 ();
  baud_rate_generator_if u_if1 ();
  baud_rate_generator_if u_if2 ();

  baud_rate_generator u_dut_def (
    .i_clk     (clk),
    .i_reset   (r_rst0),
    .o_brg_tck (u_if0.tck)
  );

  baud_rate_generator #(.CLOCK_FREQ(160), .BAUD_RATE(1), .OVERSAMPLE(16)) u_dut_small (
    .i_clk     (clk),
    .i_reset   (r_rst1),
    .o_brg_tck (u_if1.tck)
  );

  baud_rate_generator #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115200), .OVERSAMPLE(16)) u_dut_fast (
    .i_clk     (clk),
    .i_reset   (r_rst2),
    .o_brg_tck (u_if2.tck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic tck_of(input int idx);
    case (idx)
      0:       return u_if0.tck;
      1:       return u_if1.tck;
      default: return u_if2.tck;
    endcase
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_edges(input int idx, input int first, input int last);
    for (int e = first; e <= last; e++) begin
      step();
      if (tck_of(idx) === 1'b1)
        hits.push_back(e);
    end
  endtask

  task automatic test_reset();
    r_rst0 = 1'b1;
    r_rst1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (u_if0.tck !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_def cycle %0d: got %b expected 0", i, u_if0.tck);
      end
      checks++;
      if (u_if1.tck !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_small cycle %0d: got %b expected 0", i, u_if1.tck);
      end
    end
  endtask

  task automatic test_first_tick_period();
    int in_first_1000;
    checks++;
    if (baud_divisor(100_000_000, 9600, 16) != 64'sd651) begin
      errors++;
      $display("FAIL divisor_default: got %0d expected 651", baud_divisor(100_000_000, 9600, 16));
    end
    hits.delete();
    r_rst0 = 1'b0;
    run_edges(0, 1, 2000);
    checks++;
    if (hits.size() != 3) begin
      errors++;
      $display("FAIL period_def_count: got %0d ticks expected 3", hits.size());
    end else begin
      checks++;
      if (hits[0] != 651 || hits[1] != 1302 || hits[2] != 1953) begin
        errors++;
        $display("FAIL period_def_edges: got %0d,%0d,%0d expected 651,1302,1953",
                 hits[0], hits[1], hits[2]);
      end
    end
    in_first_1000 = 0;
    foreach (hits[i]) if (hits[i] <= 1000) in_first_1000++;
    checks++;
    if (in_first_1000 != 1) begin
      errors++;
      $display("FAIL period_def_1000: got %0d ticks expected 1", in_first_1000);
    end
    r_rst0 = 1'b1;
  endtask

  task automatic test_small_divisor();
    checks++;
    if (baud_divisor(160, 1, 16) != 64'sd10) begin
      errors++;
      $display("FAIL divisor_small: got %0d expected 10", baud_divisor(160, 1, 16));
    end
    r_rst1 = 1'b1;
    step();
    hits.delete();
    r_rst1 = 1'b0;
    run_edges(1, 1, 35);
    checks++;
    if (hits.size() != 3) begin
      errors++;
      $display("FAIL small_count: got %0d ticks expected 3", hits.size());
    end else begin
      checks++;
      if (hits[0] != 10 || hits[1] != 20 || hits[2] != 30) begin
        errors++;
        $display("FAIL small_edges: got %0d,%0d,%0d expected 10,20,30",
                 hits[0], hits[1], hits[2]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    r_rst1 = 1'b1;
    step();
    hits.delete();
    r_rst1 = 1'b0;
    run_edges(1, 1, 4);
    r_rst1 = 1'b1;
    run_edges(1, 5, 6);
    checks++;
    if (u_if1.tck !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: got %b expected 0", u_if1.tck);
    end
    r_rst1 = 1'b0;
    // Edge 7 is the first edge after release; next tick expected at edge 16
    run_edges(1, 7, 25);
    checks++;
    if (hits.size() != 1 || hits[0] != 16) begin
      errors++;
      $display("FAIL mid_reset_tick: got %0d ticks first at %0d expected 1 tick at 16",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
  endtask

  task automatic test_reset_terminal();
    r_rst1 = 1'b1;
    step();
    hits.delete();
    r_rst1 = 1'b0;
    run_edges(1, 1, 9);
    r_rst1 = 1'b1;
    run_edges(1, 10, 10);
    checks++;
    if (u_if1.tck !== 1'b0) begin
      errors++;
      $display("FAIL term_reset_tick: got %b expected 0", u_if1.tck);
    end
    r_rst1 = 1'b0;
    run_edges(1, 11, 25);
    checks++;
    if (hits.size() != 1 || hits[0] != 20) begin
      errors++;
      $display("FAIL term_reset_restart: got %0d ticks first at %0d expected 1 tick at 20",
               hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
  endtask

  task automatic test_rounding();
    checks++;
    if (baud_divisor(50_000_000, 115200, 16) != 64'sd27) begin
      errors++;
      $display("FAIL divisor_round: got %0d expected 27", baud_divisor(50_000_000, 115200, 16));
    end
    r_rst2 = 1'b1;
    step();
    checks++;
    if (u_if2.tck !== 1'b0) begin
      errors++;
      $display("FAIL round_reset: got %b expected 0", u_if2.tck);
    end
    hits.delete();
    r_rst2 = 1'b0;
    run_edges(2, 1, 60);
    checks++;
    if (hits.size() != 2) begin
      errors++;
      $display("FAIL round_count: got %0d ticks expected 2", hits.size());
    end else begin
      checks++;
      if (hits[0] != 27 || hits[1] != 54) begin
        errors++;
        $display("FAIL round_edges: got %0d,%0d expected 27,54", hits[0], hits[1]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    r_rst0 = 1'b1;
    r_rst1 = 1'b1;
    r_rst2 = 1'b1;
    step();
    step();
    test_reset();
    test_first_tick_period();
    test_small_divisor();
    test_reset_mid_count();
    test_reset_terminal();
    test_rounding();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
